// File: rtl/collision_score_bcd.sv
// Collision event counter with edge detect, hold-off lockout and packed BCD output.
// Overflow latches an "Err" pattern until clear or reset.
module collision_score_bcd #(
   parameter int DIGITS   = 4,
   parameter int HOLDOFF  = 16,
   parameter int HOLD_W   = 16,
   parameter int BLANK_LZ = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  hit,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  overflow,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCKOUT = 2'd1,
      ERROR   = 2'd2
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LOAD =
      (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;

   function automatic logic [4*DIGITS-1:0] zero_pattern();
      logic [4*DIGITS-1:0] p;
      p = '0;
      for (int i = 1; i < DIGITS; i++) begin
         if (BLANK_LZ != 0) p[4*i +: 4] = 4'hA;
      end
      return p;
   endfunction

   localparam logic [4*DIGITS-1:0] RST_DIGITS = zero_pattern();

   state_t              state, state_nx;
   logic [4*DIGITS-1:0] count, count_nx, inc, shown;
   logic [HOLD_W-1:0]   hold, hold_nx;
   logic                hit_q, edge_hit, all9;

   assign edge_hit = hit & ~hit_q;

   // Ripple BCD increment; a carry out of the top digit means all nines.
   always_comb begin
      logic carry;
      inc   = count;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (count[4*i +: 4] == 4'd9) begin
               inc[4*i +: 4] = 4'd0;
            end else begin
               inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      all9 = carry;
   end

   always_comb begin
      state_nx = state;
      count_nx = count;
      hold_nx  = hold;
      if (clear) begin
         state_nx = IDLE;
         count_nx = '0;
         hold_nx  = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (edge_hit) begin
                  if (all9) begin
                     state_nx = ERROR;
                  end else begin
                     count_nx = inc;
                     if (HOLDOFF > 0) begin
                        state_nx = LOCKOUT;
                        hold_nx  = HOLD_LOAD;
                     end
                  end
               end
            end
            LOCKOUT: begin
               if (hold == '0) state_nx = IDLE;
               else            hold_nx  = hold - HOLD_W'(1);
            end
            ERROR:   state_nx = ERROR;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Display image of the next state, so the output register is one edge behind hit.
   always_comb begin
      logic lead;
      shown = count_nx;
      lead  = 1'b1;
      if (state_nx == ERROR) begin
         for (int i = 0; i < DIGITS; i++) shown[4*i +: 4] = 4'hA;
         shown[4*(DIGITS-1) +: 4] = 4'hE;
         shown[4*(DIGITS-2) +: 4] = 4'hF;
         shown[4*(DIGITS-3) +: 4] = 4'hF;
      end else if (BLANK_LZ != 0) begin
         for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && count_nx[4*i +: 4] == 4'd0) shown[4*i +: 4] = 4'hA;
            else                                     lead = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         hold     <= '0;
         hit_q    <= 1'b1;
         digits   <= RST_DIGITS;
         overflow <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         count    <= count_nx;
         hold     <= hold_nx;
         hit_q    <= hit;
         digits   <= shown;
         overflow <= (state_nx == ERROR);
         busy     <= (state_nx == LOCKOUT);
      end
   end

endmodule

// File: tb/tb_collision_score_bcd.sv
// Scoreboard bench for collision_score_bcd: four instances with different
// hold-off / blanking settings, expectations queued with a due cycle.
module tb_collision_score_bcd;

   typedef struct {
      int          due;
      int          inst;
      logic [15:0] dig;
      logic        ov;
      logic        bz;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  hit = '0;
   logic [3:0]  clear = '0;
   logic [15:0] dg0, dg1, dg2, dg3;
   logic        ov0, ov1, ov2, ov3;
   logic        bz0, bz1, bz2, bz3;

   int   cyc = 0;
   int   npass = 0;
   int   ntot = 0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   collision_score_bcd #(.DIGITS(4), .HOLDOFF(4), .HOLD_W(16), .BLANK_LZ(0)) u0 (
      .clk(clk), .rst(rst), .hit(hit[0]), .clear(clear[0]),
      .digits(dg0), .overflow(ov0), .busy(bz0));
   collision_score_bcd #(.DIGITS(4), .HOLDOFF(0), .HOLD_W(16), .BLANK_LZ(0)) u1 (
      .clk(clk), .rst(rst), .hit(hit[1]), .clear(clear[1]),
      .digits(dg1), .overflow(ov1), .busy(bz1));
   collision_score_bcd #(.DIGITS(4), .HOLDOFF(8), .HOLD_W(16), .BLANK_LZ(0)) u2 (
      .clk(clk), .rst(rst), .hit(hit[2]), .clear(clear[2]),
      .digits(dg2), .overflow(ov2), .busy(bz2));
   collision_score_bcd #(.DIGITS(4), .HOLDOFF(0), .HOLD_W(16), .BLANK_LZ(1)) u3 (
      .clk(clk), .rst(rst), .hit(hit[3]), .clear(clear[3]),
      .digits(dg3), .overflow(ov3), .busy(bz3));

   task automatic chk(string nm, logic [15:0] ad, logic [15:0] ed,
                      logic ao, logic eo, logic ab, logic eb);
      ntot++;
      if (ad === ed && ao === eo && ab === eb) begin
         npass++;
      end else begin
         $display("FAIL %s: got digits=%h ovf=%b busy=%b, want digits=%h ovf=%b busy=%b",
                  nm, ad, ao, ab, ed, eo, eb);
      end
   endtask

   task automatic compare(exp_t e);
      logic [15:0] d;
      logic        o, b;
      case (e.inst)
         0:       begin d = dg0; o = ov0; b = bz0; end
         1:       begin d = dg1; o = ov1; b = bz1; end
         2:       begin d = dg2; o = ov2; b = bz2; end
         default: begin d = dg3; o = ov3; b = bz3; end
      endcase
      chk(e.name, d, e.dig, o, e.ov, b, e.bz);
   endtask

   // Monitor: pops every expectation that has come due at this falling edge.
   initial begin
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].due <= cyc) compare(q.pop_front());
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_at(int i, logic [15:0] d, logic o, logic b,
                            string nm, int dly);
      exp_t e;
      e.due  = cyc + dly;
      e.inst = i;
      e.dig  = d;
      e.ov   = o;
      e.bz   = b;
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic ev(int i, int n);
      repeat (n) begin
         hit[i] = 1'b1; step();
         hit[i] = 1'b0; step();
      end
   endtask

   task automatic pulse_exp(int i, logic [15:0] d, logic o, logic b, string nm);
      hit[i] = 1'b1;
      expect_at(i, d, o, b, nm, 1);
      step();
      hit[i] = 1'b0;
      step();
   endtask

   task automatic do_clear(int i, logic [15:0] d, string nm);
      clear[i] = 1'b1;
      expect_at(i, d, 1'b0, 1'b0, nm, 1);
      step();
      clear[i] = 1'b0;
      step();
   endtask

   initial begin
      step(2);
      rst = 1'b0;
      expect_at(0, 16'h0000, 0, 0, "rst_u0", 1);
      expect_at(1, 16'h0000, 0, 0, "rst_u1", 1);
      expect_at(2, 16'h0000, 0, 0, "rst_u2", 1);
      expect_at(3, 16'hAAA0, 0, 0, "rst_u3_blank", 1);
      step(2);

      // Three pulses, lockout of four cycles after each.
      for (int k = 1; k <= 3; k++) begin
         hit[0] = 1'b1;
         expect_at(0, 16'(k), 0, 1, "t1_count", 1);
         expect_at(0, 16'(k), 0, 1, "t1_busy_last", 4);
         expect_at(0, 16'(k), 0, 0, "t1_busy_end", 5);
         step();
         hit[0] = 1'b0;
         step(9);
      end

      // Carry propagation with no lockout.
      ev(1, 8);
      pulse_exp(1, 16'h0009, 0, 0, "t2_9");
      pulse_exp(1, 16'h0010, 0, 0, "t2_10");
      ev(1, 88);
      pulse_exp(1, 16'h0099, 0, 0, "t2_99");
      pulse_exp(1, 16'h0100, 0, 0, "t2_100");
      do_clear(1, 16'h0000, "t2_clear");

      // Overflow into the error pattern.
      ev(1, 9998);
      pulse_exp(1, 16'h9999, 0, 0, "t4_9999");
      pulse_exp(1, 16'hEFFA, 1, 0, "t4_err");
      pulse_exp(1, 16'hEFFA, 1, 0, "t4_err_hold");
      do_clear(1, 16'h0000, "t4_clear");

      // Edges inside the lockout window are ignored.
      hit[2] = 1'b1;
      expect_at(2, 16'h0001, 0, 1, "t3_first", 1);
      step();
      hit[2] = 1'b0;
      step(2);
      hit[2] = 1'b1;
      expect_at(2, 16'h0001, 0, 1, "t3_locked", 1);
      step();
      hit[2] = 1'b0;
      step(5);
      hit[2] = 1'b1;
      expect_at(2, 16'h0002, 0, 1, "t3_after", 1);
      step(20);
      expect_at(2, 16'h0002, 0, 0, "t3_level", 1);
      step();
      hit[2] = 1'b0;
      step();

      // Clear beats a simultaneous edge; the held level never counts.
      hit[0]   = 1'b1;
      clear[0] = 1'b1;
      expect_at(0, 16'h0000, 0, 0, "t5_clear_hit", 1);
      step();
      clear[0] = 1'b0;
      step(5);
      expect_at(0, 16'h0000, 0, 0, "t5_held", 1);
      step();
      hit[0] = 1'b0;
      step();

      // Asynchronous reset in the middle of lockout.
      hit[0] = 1'b1;
      expect_at(0, 16'h0001, 0, 1, "t5_lock", 1);
      step(2);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_u0", dg0, 16'h0000, ov0, 1'b0, bz0, 1'b0);
      chk("t5_async_u3", dg3, 16'hAAA0, ov3, 1'b0, bz3, 1'b0);
      step(2);
      rst = 1'b0;
      step(3);
      expect_at(0, 16'h0000, 0, 0, "t5_release", 1);
      step();
      hit[0] = 1'b0;
      step();

      // Leading-zero blanking.
      expect_at(3, 16'hAAA0, 0, 0, "t6_zero", 1);
      step();
      ev(3, 4);
      pulse_exp(3, 16'hAAA5, 0, 0, "t6_five");
      ev(3, 4);
      pulse_exp(3, 16'hAA10, 0, 0, "t6_ten");

      for (int w = 0; w < 50 && q.size() > 0; w++) step();
      if (q.size() > 0) begin
         ntot++;
         $display("FAIL drain: %0d expectations pending, want 0", q.size());
      end
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
